// File: rtl/block_raster_writer.sv
// Block-to-raster write address generator: takes 8x8 block rows in decode order and
// emits one registered frame-buffer write per row, with optional per-frame bank toggling.
module block_raster_writer #(
  parameter  int W_BLOCKS   = 40,
  parameter  int H_BLOCKS   = 30,
  parameter  int DOUBLE_BUF = 1,
  localparam int ADDR_W     = $clog2(W_BLOCKS*H_BLOCKS*8) + DOUBLE_BUF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [63:0]       row_in,
  input  logic              valid_in,
  input  logic              final_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic [63:0]       data_out,
  output logic              we_out,
  output logic              frame_done_out,
  output logic              bank_out,
  output logic              error_out
);

  localparam int WA = ADDR_W - DOUBLE_BUF;
  localparam int CW = (W_BLOCKS > 1) ? $clog2(W_BLOCKS) : 1;
  localparam int RW = (H_BLOCKS > 1) ? $clog2(H_BLOCKS) : 1;
  localparam logic [CW-1:0] LAST_COL     = CW'(W_BLOCKS - 1);
  localparam logic [RW-1:0] LAST_ROW     = RW'(H_BLOCKS - 1);
  localparam logic [WA-1:0] STEP_ROW     = WA'(W_BLOCKS);
  localparam logic [WA-1:0] STEP_BLK_ROW = WA'(7*W_BLOCKS + 1);

  logic [2:0]        r_q, r_d;
  logic [CW-1:0]     blk_col_q, blk_col_d;
  logic [RW-1:0]     blk_row_q, blk_row_d;
  logic [WA-1:0]     blk_base_q, blk_base_d;
  logic [WA-1:0]     r_off_q, r_off_d;
  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       data_q, data_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              bank_q, bank_d;
  logic              err_q, err_d;

  logic [WA-1:0]     word;
  logic [ADDR_W-1:0] addr_full;
  logic              at_last;
  logic              frame_end;

  assign word = blk_base_q + r_off_q;

  generate
    if (DOUBLE_BUF != 0) begin : g_bank
      assign addr_full = {wr_bank_q, word};
    end else begin : g_single
      assign addr_full = word;
    end
  endgenerate

  assign at_last   = (r_q == 3'd7) && (blk_col_q == LAST_COL) && (blk_row_q == LAST_ROW);
  assign frame_end = final_in | at_last;

  always_comb begin
    r_d        = r_q;
    blk_col_d  = blk_col_q;
    blk_row_d  = blk_row_q;
    blk_base_d = blk_base_q;
    r_off_d    = r_off_q;
    wr_bank_d  = wr_bank_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    bank_d     = bank_q;
    err_d      = err_q;
    if (valid_in) begin
      we_d   = 1'b1;
      addr_d = addr_full;
      data_d = row_in;
      done_d = frame_end;
      // A frame end that is not exactly the last row means the stream and geometry disagree.
      err_d  = err_q | (final_in ^ at_last);
      if (frame_end) begin
        r_d        = 3'd0;
        blk_col_d  = '0;
        blk_row_d  = '0;
        blk_base_d = '0;
        r_off_d    = '0;
        bank_d     = wr_bank_q;
        wr_bank_d  = (DOUBLE_BUF != 0) ? ~wr_bank_q : 1'b0;
      end else if (r_q != 3'd7) begin
        r_d     = r_q + 3'd1;
        r_off_d = r_off_q + STEP_ROW;
      end else if (blk_col_q != LAST_COL) begin
        r_d        = 3'd0;
        r_off_d    = '0;
        blk_col_d  = blk_col_q + CW'(1);
        blk_base_d = blk_base_q + WA'(1);
      end else begin
        r_d        = 3'd0;
        r_off_d    = '0;
        blk_col_d  = '0;
        blk_row_d  = blk_row_q + RW'(1);
        blk_base_d = blk_base_q + STEP_BLK_ROW;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_q        <= 3'd0;
      blk_col_q  <= '0;
      blk_row_q  <= '0;
      blk_base_q <= '0;
      r_off_q    <= '0;
      wr_bank_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      bank_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      r_q        <= r_d;
      blk_col_q  <= blk_col_d;
      blk_row_q  <= blk_row_d;
      blk_base_q <= blk_base_d;
      r_off_q    <= r_off_d;
      wr_bank_q  <= wr_bank_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      done_q     <= done_d;
      bank_q     <= bank_d;
      err_q      <= err_d;
    end
  end

  assign addr_out       = addr_q;
  assign data_out       = data_q;
  assign we_out         = we_q;
  assign frame_done_out = done_q;
  assign bank_out       = bank_q;
  assign error_out      = err_q;

endmodule
